// File: rtl/servisia_mem_ctrl.sv
// servisia_mem_ctrl: arbitrates SERV ibus/dbus onto an 8-bit memory port,
// splitting each 32-bit Wishbone access into four little-endian byte cycles.
module servisia_mem_ctrl #(
  parameter bit ALLOW_FLASH_WRITE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ibus_adr_i,
  input  logic        ibus_cyc_i,
  output logic [31:0] ibus_rdt_o,
  output logic        ibus_ack_o,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  input  logic [3:0]  dbus_sel_i,
  input  logic        dbus_we_i,
  input  logic        dbus_cyc_i,
  output logic [31:0] dbus_rdt_o,
  output logic        dbus_ack_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [20:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    CAPT,
    ACK
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [18:0] base;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        gnt_d;
  logic        last_d;
  logic        pick_d;
  logic        wr_ok;
  logic        xfer;
  logic        unused;

  assign unused = ^{ibus_adr_i[31:21], ibus_adr_i[1:0],
                    dbus_adr_i[31:21], dbus_adr_i[1:0]};

  // Round-robin on a tie: serve whichever bus did not win last time
  assign pick_d = dbus_cyc_i & (~ibus_cyc_i | ~last_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      base   <= '0;
      we     <= 1'b0;
      sel    <= 4'd0;
      wdata  <= '0;
      data   <= '0;
      gnt_d  <= 1'b0;
      last_d <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ibus_cyc_i | dbus_cyc_i) begin
            gnt_d  <= pick_d;
            last_d <= pick_d;
            base   <= pick_d ? dbus_adr_i[20:2] : ibus_adr_i[20:2];
            we     <= pick_d & dbus_we_i;
            sel    <= pick_d ? dbus_sel_i : 4'd0;
            wdata  <= pick_d ? dbus_dat_i : 32'd0;
            cnt    <= 2'd0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (!we && cnt != 2'd0)
            data[{cnt - 2'd1, 3'b000} +: 8] <= mem_rdata_i;
          if (cnt == 2'd3)
            state <= we ? ACK : CAPT;
          else
            cnt <= cnt + 2'd1;
        end
        CAPT: begin
          data[31:24] <= mem_rdata_i;
          state       <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign xfer  = (state == XFER);
  assign wr_ok = ALLOW_FLASH_WRITE | base[18];

  assign mem_read_o  = xfer & ~we;
  assign mem_write_o = xfer & we & sel[cnt] & wr_ok;
  assign mem_addr_o  = xfer ? {base, cnt} : 21'd0;
  assign mem_wdata_o = (xfer & we) ? wdata[{cnt, 3'b000} +: 8] : 8'd0;

  assign ibus_ack_o = (state == ACK) & ~gnt_d;
  assign dbus_ack_o = (state == ACK) & gnt_d;
  assign ibus_rdt_o = data;
  assign dbus_rdt_o = data;

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// tb_servisia_mem_ctrl: vector table plus scoreboard of acks/read data,
// with hand sequences for arbitration ties and mid-transfer reset.
module tb_servisia_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus_adr = '0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] dbus_adr = '0;
  logic [31:0] dbus_dat = '0;
  logic [3:0]  dbus_sel = '0;
  logic        dbus_we = 1'b0;
  logic        dbus_cyc = 1'b0;
  logic [7:0]  mem_rdata;

  logic [31:0] ibus_rdt, dbus_rdt;
  logic        ibus_ack, dbus_ack;
  logic        mem_read, mem_write;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;

  logic [31:0] ibus_rdt_f, dbus_rdt_f;
  logic        ibus_ack_f, dbus_ack_f;
  logic        mem_read_f, mem_write_f;
  logic [20:0] mem_addr_f;
  logic [7:0]  mem_wdata_f;
  logic        unused_f;

  always #5 clk = ~clk;

  servisia_mem_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ibus_adr_i(ibus_adr), .ibus_cyc_i(ibus_cyc),
    .ibus_rdt_o(ibus_rdt), .ibus_ack_o(ibus_ack),
    .dbus_adr_i(dbus_adr), .dbus_dat_i(dbus_dat),
    .dbus_sel_i(dbus_sel), .dbus_we_i(dbus_we),
    .dbus_cyc_i(dbus_cyc),
    .dbus_rdt_o(dbus_rdt), .dbus_ack_o(dbus_ack),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  servisia_mem_ctrl #(.ALLOW_FLASH_WRITE(1'b1)) dut_fw (
    .clk_i(clk), .rst_ni(rst_n),
    .ibus_adr_i(ibus_adr), .ibus_cyc_i(ibus_cyc),
    .ibus_rdt_o(ibus_rdt_f), .ibus_ack_o(ibus_ack_f),
    .dbus_adr_i(dbus_adr), .dbus_dat_i(dbus_dat),
    .dbus_sel_i(dbus_sel), .dbus_we_i(dbus_we),
    .dbus_cyc_i(dbus_cyc),
    .dbus_rdt_o(dbus_rdt_f), .dbus_ack_o(dbus_ack_f),
    .mem_read_o(mem_read_f), .mem_write_o(mem_write_f),
    .mem_addr_o(mem_addr_f), .mem_wdata_o(mem_wdata_f),
    .mem_rdata_i(mem_rdata)
  );

  assign unused_f = ^{ibus_rdt_f, dbus_rdt_f, ibus_ack_f, dbus_ack_f,
                      mem_read_f, mem_addr_f, mem_wdata_f};

  // Byte memory model: registered read, contents byte i = i except 0x40..43
  logic [7:0] mem [256];
  logic       init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h40] <= 8'h11;
      mem[8'h41] <= 8'h22;
      mem[8'h42] <= 8'h33;
      mem[8'h43] <= 8'h44;
      init_done  <= 1'b1;
    end else begin
      if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt;
    logic [3:0]  wm;
    logic [3:0]  wm_f;
  } vec_t;

  typedef struct {
    bit          d;
    logic [31:0] rdt;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vt[8];
  vec_t        vr;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic on_ack(input bit d_ack);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected ack: got d=%0d expected none", d_ack);
    end else begin
      e = sbq.pop_front();
      chk("ack bus", 32'(d_ack), 32'(e.d));
      chk("ack rdt", d_ack ? dbus_rdt : ibus_rdt, e.rdt);
    end
  endtask

  task automatic do_access(input vec_t v, input int idx);
    int lat;
    bit got;
    exp_t e;
    @(negedge clk);
    if (v.d) begin
      dbus_adr = v.adr;
      dbus_dat = v.dat;
      dbus_sel = v.sel;
      dbus_we  = v.we;
      dbus_cyc = 1'b1;
    end else begin
      ibus_adr = v.adr;
      ibus_cyc = 1'b1;
    end
    e.d   = v.d;
    e.rdt = v.we ? last_rd : v.rdt;
    sbq.push_back(e);
    if (!v.we) last_rd = v.rdt;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) begin
        int k = lat - 1;
        chk($sformatf("v%0d rd strobe %0d", idx, k),
            32'(mem_read), 32'(!v.we));
        chk($sformatf("v%0d wr strobe %0d", idx, k),
            32'(mem_write), 32'(v.wm[k]));
        chk($sformatf("v%0d fw wr strobe %0d", idx, k),
            32'(mem_write_f), 32'(v.wm_f[k]));
        chk($sformatf("v%0d addr %0d", idx, k),
            32'(mem_addr), 32'({v.adr[20:2], k[1:0]}));
        if (v.wm[k])
          chk($sformatf("v%0d wdata %0d", idx, k),
              32'(mem_wdata), 32'(v.dat[8*k +: 8]));
      end else begin
        chk($sformatf("v%0d idle strobes", idx),
            32'(mem_read | mem_write), 32'd0);
      end
      chk($sformatf("v%0d other ack", idx),
          32'(v.d ? ibus_ack : dbus_ack), 32'd0);
      if (v.d ? dbus_ack : ibus_ack) begin
        got = 1'b1;
        on_ack(v.d);
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), v.we ? 32'd5 : 32'd6);
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n_ack;
    exp_t e;

    vt[0] = '{1'b0, 1'b0, 32'h0010_0040, 32'h0, 4'h0, 32'h4433_2211, 4'b0000, 4'b0000};
    vt[1] = '{1'b1, 1'b1, 32'h0010_0008, 32'hA1B2_C3D4, 4'b0101, 32'h0, 4'b0101, 4'b0101};
    vt[2] = '{1'b1, 1'b0, 32'h0010_0008, 32'h0, 4'b0000, 32'h0BB2_09D4, 4'b0000, 4'b0000};
    vt[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'h5566_7788, 4'b1111, 32'h0, 4'b0000, 4'b1111};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000};
    vt[5] = '{1'b1, 1'b1, 32'h0010_0020, 32'hDEAD_BEEF, 4'b0000, 32'h0, 4'b0000, 4'b0000};
    vt[6] = '{1'b0, 1'b0, 32'hFFF0_0043, 32'h0, 4'h0, 32'h4433_2211, 4'b0000, 4'b0000};
    vt[7] = '{1'b1, 1'b0, 32'h0010_000C, 32'h0, 4'b1010, 32'h0F0E_0D0C, 4'b0000, 4'b0000};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst mem_read", 32'(mem_read), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst acks", 32'({ibus_ack, dbus_ack}), 32'd0);
    chk("rst ibus_rdt", ibus_rdt, 32'd0);
    chk("rst dbus_rdt", dbus_rdt, 32'd0);
    rst_n = 1'b1;

    // Simultaneous requests from reset: dbus first, then alternate
    @(negedge clk);
    ibus_adr = 32'h0010_0040;
    dbus_adr = 32'h0010_000C;
    dbus_we  = 1'b0;
    dbus_sel = 4'b1111;
    ibus_cyc = 1'b1;
    dbus_cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e.d   = (i % 2 == 0);
      e.rdt = e.d ? 32'h0F0E_0D0C : 32'h4433_2211;
      sbq.push_back(e);
    end
    last_rd = 32'h4433_2211;
    n_ack = 0;
    for (int c = 0; c < 60 && n_ack < 6; c++) begin
      @(negedge clk);
      chk("tie dual ack", 32'(ibus_ack & dbus_ack), 32'd0);
      if (ibus_ack | dbus_ack) begin
        n_ack++;
        on_ack(dbus_ack);
      end
    end
    chk("tie ack count", 32'(n_ack), 32'd6);
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) do_access(vt[i], i);

    // Reset during a write, byte 2
    @(negedge clk);
    dbus_adr = 32'h0010_0030;
    dbus_dat = 32'h1234_5678;
    dbus_sel = 4'b1111;
    dbus_we  = 1'b1;
    dbus_cyc = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre-rst wr strobe", 32'(mem_write), 32'd1);
    chk("pre-rst addr", 32'(mem_addr), 32'h0010_0032);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst wr strobe", 32'(mem_write), 32'd0);
    chk("async rst addr", 32'(mem_addr), 32'd0);
    chk("async rst rdt", dbus_rdt, 32'd0);
    dbus_cyc = 1'b0;
    last_rd  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post-rst acks", 32'({ibus_ack, dbus_ack}), 32'd0);
      chk("post-rst strobes", 32'({mem_read, mem_write}), 32'd0);
    end
    vr = '{1'b0, 1'b0, 32'h0010_0040, 32'h0, 4'h0, 32'h4433_2211, 4'b0000, 4'b0000};
    do_access(vr, 8);

    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servisia_mem_ctrl.md
Name: servisia_mem_ctrl

Overview:
- Arbitrates the SERV instruction bus and data bus onto the single 8-bit memory port: 21-bit byte address, bit 20 = 1 selects SRAM, bit 20 = 0 selects flash.
- Converts each 32-bit Wishbone-classic access into four sequential byte accesses, little-endian.
- Sits between the core and the memory block, and drives its read, write, address and write-data inputs.

Parameters:
- ALLOW_FLASH_WRITE, 0: when 0, write strobes to addresses with bit 20 = 0 are suppressed. The access still completes and is acked.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- ibus_adr_i  in  32  instruction byte address; bits [1:0] and [31:21] ignored
- ibus_cyc_i  in  1  instruction request (read-only)
- ibus_rdt_o  out  32  instruction read data
- ibus_ack_o  out  1  instruction ack, 1-cycle pulse
- dbus_adr_i  in  32  data byte address; bits [1:0] and [31:21] ignored
- dbus_dat_i  in  32  data write data
- dbus_sel_i  in  4  byte enables; bit k = byte k
- dbus_we_i  in  1  1 = write, 0 = read
- dbus_cyc_i  in  1  data request
- dbus_rdt_o  out  32  data read data
- dbus_ack_o  out  1  data ack, 1-cycle pulse
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  21  memory byte address
- mem_wdata_o  out  8  memory write byte
- mem_rdata_i  in  8  memory read byte; registered in memory, valid in the cycle after mem_read_o

Behaviour:
- Reset (async, while rst_ni = 0):
  - state = IDLE, byte counter = 0, data register = 0, last_grant = IBUS.
  - All outputs 0, including mem strobes and both acks.
  - Reset mid-transaction aborts it immediately. No ack is issued.
- FSM states: IDLE, XFER, CAPT, ACK.
- IDLE:
  - If exactly one cyc is high, grant that bus.
  - If both are high, grant the bus != last_grant (round-robin). First tie after reset goes to DBUS.
  - On grant: latch base = adr[20:2], we (forced to 0 for IBUS), sel, wdata; set last_grant; cnt = 0; go to XFER.
  - No mem strobes in IDLE.
- XFER (cnt 0..3):
  - mem_addr_o = {base, cnt[1:0]}.
  - Read: mem_read_o = 1.
  - Write: mem_write_o = sel[cnt] && (ALLOW_FLASH_WRITE || base[18] == 1). base[18] is address bit 20. mem_wdata_o = wdata[8*cnt+7 : 8*cnt].
  - Never assert both strobes.
  - Read, cnt >= 1: capture mem_rdata_i into data[8*(cnt-1) +: 8].
  - cnt == 3: a read goes to CAPT, a write goes to ACK. Otherwise cnt++.
- CAPT: capture mem_rdata_i into data[31:24]; strobes 0; go to ACK.
- ACK:
  - Assert the granted bus's ack for exactly one cycle; go to IDLE.
  - A write does not modify the data register.
- Latency:
  - Read: ack 6 cycles after the grant cycle (grant, 4× XFER, CAPT, ACK). Total 6 cycles from cyc seen to ack.
  - Write: ack 5 cycles after the grant cycle.
- Read data:
  - ibus_rdt_o and dbus_rdt_o both equal the shared data register.
  - Valid during ACK; holds its value until the next read capture.
- Write sel = 0000: no write strobes; still 5-cycle ack.
- DBUS reads ignore sel; all 4 bytes are read.
- Requester protocol: cyc held until ack, dropped in the cycle after ack.
  - If cyc drops mid-transaction, the transaction runs to completion and ack is still pulsed.
  - A cyc still high in the IDLE cycle right after ACK is treated as a new request.
- The non-granted request waits; it is served next.
- Address wrap: cnt never carries into base. Byte addresses are base*4 + 0..3 only.

Test Plan:
1. IBUS read at 0x100040, memory model returns bytes 11,22,33,44 → mem_read_o high for 4 cycles, addresses 0x100040..43; ibus_rdt_o = 0x44332211; ibus_ack_o pulses 6 cycles after cyc seen; dbus_ack_o stays 0.
2. DBUS write adr 0x100008, dat 0xA1B2C3D4, sel 0101 → mem_write_o only at 0x100008 (wdata D4) and 0x10000A (wdata B2); ack at cycle 5.
3. DBUS write to flash 0x000010, sel 1111, ALLOW_FLASH_WRITE = 0 → no write strobes, ack at cycle 5. With ALLOW_FLASH_WRITE = 1 → 4 strobes.
4. Both cyc high from reset → DBUS served first, then IBUS. Keep both asserting back-to-back → grants alternate, with no ack starvation.
5. Assert rst_ni = 0 in XFER cnt = 2 of a write → strobes drop to 0 asynchronously, no ack, FSM in IDLE. After release, a new IBUS read completes normally.
6. Unaligned adr 0x100043 with upper bits 0xFFE00000 set → accesses 0x100040..43.
